button_debounce: RTL and testbench
==================================

# button_debounce

Input conditioner for the push-button inputs on the iCE40 boards, clocked from the PLL output `fclock` and held in reset until PLL lock. It synchronises the raw, bouncing pad signal and produces a clean debounced level. It also produces single-cycle press, release and long-press event pulses and a wrapping press counter for the fabric logic that consumes button events (LED/mode control).

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, 500000: consecutive cycles of a changed synchronised level required before the debounced level follows (5 ms at 100 MHz); legal range 1..2^21-1.
- `LONG_CYCLES`, 100000000: cycles the debounced level must stay pressed before `long_pulse` fires; legal range 1..2^27-1.
- `ACTIVE_HIGH`, 1: 1 = pad reads 1 when pressed; 0 = pad reads 0 when pressed (inverted at input).

Ports:
- `fclock` input 1: system clock (PLL output).
- `lock` input 1: asynchronous, active-low reset (PLL lock; low = reset).
- `button` input 1: raw asynchronous pad input.
- `pressed` output 1: debounced level, 1 = pressed.
- `press_pulse` output 1: one-cycle pulse on a debounced press.
- `release_pulse` output 1: one-cycle pulse on a debounced release.
- `long_pulse` output 1: one-cycle pulse, at most once per press, after `LONG_CYCLES` held.
- `press_count` output 8: number of debounced presses, mod 256.

## Operation
- Input normalisation: `b = ACTIVE_HIGH ? button : ~button`.
- Synchroniser: two flops `s1 <= b`, `s2 <= s1`. Both reset to 0 (released).
- Debounce counter `dcnt`, 21 bits:
  - If `s2 == pressed`, clear to 0.
  - Else if `dcnt == DEBOUNCE_CYCLES-1`, toggle `pressed` and clear `dcnt`.
  - Else increment `dcnt`.
  - Any single cycle of agreement restarts the count. A glitch shorter than `DEBOUNCE_CYCLES` cycles never reaches `pressed`.
- Event FSM, states `IDLE`, `HELD`, `LONG`:
  - `IDLE`: on debounced press, assert `press_pulse`, increment `press_count` (wraps 255→0), clear `lcnt` (27 bits), go to `HELD`.
  - `HELD`: on debounced release, assert `release_pulse` and go to `IDLE`. Otherwise, if `lcnt == LONG_CYCLES-1`, assert `long_pulse` and go to `LONG`; else increment `lcnt`.
  - `LONG`: `lcnt` frozen. On debounced release, assert `release_pulse` and go to `IDLE`.
  - Release takes priority over long-press detection in the same cycle. In that case there is no `long_pulse`.
- All outputs are registered. Pulses are high for exactly one `fclock` cycle.
- `lock` low, asynchronous: `s1`, `s2`, `dcnt`, `lcnt` = 0; state = `IDLE`; `pressed`, `press_pulse`, `release_pulse`, `long_pulse` = 0; `press_count` = 0.
- Reset mid-press: everything clears with no `release_pulse`. If the button is still held after `lock` rises, it is detected as a fresh press.

## Timing
- Raw edge sampled at edge k → `s2` updated after edge k+1 → `pressed` and the corresponding pulse change after edge k+1+`DEBOUNCE_CYCLES`.
- Total press/release latency is `DEBOUNCE_CYCLES`+2 cycles (the pulse is asserted in the same cycle `pressed` changes).
- `long_pulse` is asserted `LONG_CYCLES` cycles after `press_pulse`. Example: `press_pulse` in cycle P gives `long_pulse` in cycle P+`LONG_CYCLES`.
- Minimum spacing between a press and the following release is `DEBOUNCE_CYCLES` cycles. Pulses never overlap.
- First press after `lock` deassertion, with the button already held, appears after `DEBOUNCE_CYCLES`+2 cycles.

## Test plan
Test parameters: `DEBOUNCE_CYCLES`=4, `LONG_CYCLES`=10, `ACTIVE_HIGH`=1.
- Reset: hold `lock`=0 while toggling `button` → all outputs 0. Release `lock` with `button`=0 for 20 cycles → no pulses, `press_count`=0.
- Clean press: `button` 0→1, stable → `press_pulse` exactly once, 6 cycles after the edge, with `pressed`=1 from that cycle. `button` back to 0 for 5 cycles → `release_pulse` once, 6 cycles after the falling edge; no `long_pulse`.
- Bounce: `button` 1 for 3 cycles, 0 for 1, 1 for 3, 0 thereafter → no `press_pulse`, `pressed` stays 0. A further 1-cycle low glitch inside a held press → no `release_pulse`.
- Long press: hold `button`=1 for 40 cycles → `press_pulse` at P, `long_pulse` exactly once at P+10, nothing more until release, then `release_pulse` once.
- Wrap and polarity:
  - 257 clean presses → `press_count`=1.
  - Rerun the clean-press case with `ACTIVE_HIGH`=0 and inverted stimulus → identical response.
- Async reset mid-press: assert `lock` low between edges while `pressed`=1 → outputs 0 immediately, no `release_pulse`. Release `lock` with `button` still 1 → new `press_pulse` 6 cycles later, `press_count`=1.

Source files
------------

// File: rtl/button_debounce.sv
// Push-button conditioner: synchronises the raw pad, debounces it and emits
// registered press/release/long-press pulses plus a wrapping press counter.
module button_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int LONG_CYCLES     = 100000000,
    parameter int ACTIVE_HIGH     = 1
) (
    input  logic       fclock,
    input  logic       lock,
    input  logic       button,
    output logic       pressed,
    output logic       press_pulse,
    output logic       release_pulse,
    output logic       long_pulse,
    output logic [7:0] press_count
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HELD = 2'd1,
        ST_LONG = 2'd2
    } state_t;

    localparam logic [20:0] DEB_LAST  = 21'(DEBOUNCE_CYCLES - 1);
    localparam logic [26:0] LONG_LAST = 27'(LONG_CYCLES - 1);

    logic        w_b;
    logic        r_s1;
    logic        r_s2;
    logic [20:0] r_dcnt;
    logic        r_pressed;
    logic        w_toggle;
    logic        w_rise;
    logic        w_fall;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [26:0] r_lcnt;
    logic [26:0] w_lcnt_nxt;
    logic [7:0]  r_count;
    logic [7:0]  w_count_nxt;
    logic        r_press_pulse;
    logic        r_release_pulse;
    logic        r_long_pulse;
    logic        w_press_nxt;
    logic        w_release_nxt;
    logic        w_long_nxt;

    assign w_b = (ACTIVE_HIGH != 0) ? button : ~button;

    // Two-flop synchroniser for the asynchronous pad.
    always_ff @(posedge fclock or negedge lock) begin
        if (!lock) begin
            r_s1 <= 1'b0;
            r_s2 <= 1'b0;
        end else begin
            r_s1 <= w_b;
            r_s2 <= r_s1;
        end
    end

    // Debounce counter: any cycle of agreement restarts the count.
    always_ff @(posedge fclock or negedge lock) begin
        if (!lock) begin
            r_dcnt    <= 21'd0;
            r_pressed <= 1'b0;
        end else if (r_s2 == r_pressed) begin
            r_dcnt <= 21'd0;
        end else if (r_dcnt == DEB_LAST) begin
            r_pressed <= ~r_pressed;
            r_dcnt    <= 21'd0;
        end else begin
            r_dcnt <= r_dcnt + 21'd1;
        end
    end

    // The event FSM sees the toggle in the same cycle the debounced level flips,
    // so each pulse lines up with the change of pressed.
    assign w_toggle = (r_s2 != r_pressed) && (r_dcnt == DEB_LAST);
    assign w_rise   = w_toggle & ~r_pressed;
    assign w_fall   = w_toggle & r_pressed;

    // Event FSM state and registered outputs.
    always_ff @(posedge fclock or negedge lock) begin
        if (!lock) begin
            r_state         <= ST_IDLE;
            r_lcnt          <= 27'd0;
            r_count         <= 8'd0;
            r_press_pulse   <= 1'b0;
            r_release_pulse <= 1'b0;
            r_long_pulse    <= 1'b0;
        end else begin
            r_state         <= w_state_nxt;
            r_lcnt          <= w_lcnt_nxt;
            r_count         <= w_count_nxt;
            r_press_pulse   <= w_press_nxt;
            r_release_pulse <= w_release_nxt;
            r_long_pulse    <= w_long_nxt;
        end
    end

    // Event FSM next state; release wins over a coincident long-press.
    always_comb begin
        w_state_nxt   = r_state;
        w_lcnt_nxt    = r_lcnt;
        w_count_nxt   = r_count;
        w_press_nxt   = 1'b0;
        w_release_nxt = 1'b0;
        w_long_nxt    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_rise) begin
                    w_press_nxt = 1'b1;
                    w_count_nxt = r_count + 8'd1;
                    w_lcnt_nxt  = 27'd0;
                    w_state_nxt = ST_HELD;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_HELD: begin
                if (w_fall) begin
                    w_release_nxt = 1'b1;
                    w_state_nxt   = ST_IDLE;
                end else if (r_lcnt == LONG_LAST) begin
                    w_long_nxt  = 1'b1;
                    w_state_nxt = ST_LONG;
                end else begin
                    w_lcnt_nxt = r_lcnt + 27'd1;
                end
            end
            ST_LONG: begin
                if (w_fall) begin
                    w_release_nxt = 1'b1;
                    w_state_nxt   = ST_IDLE;
                end else begin
                    w_state_nxt = ST_LONG;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_lcnt_nxt  = 27'd0;
            end
        endcase
    end

    assign pressed       = r_pressed;
    assign press_pulse   = r_press_pulse;
    assign release_pulse = r_release_pulse;
    assign long_pulse    = r_long_pulse;
    assign press_count   = r_count;

endmodule

// File: tb/tb_button_debounce.sv
// Bench for button_debounce: an active-high and an active-low instance share one
// stimulus; pulse cycles are predicted into queues and checked every cycle.
module tb_button_debounce;

    typedef struct {
        logic       b;
        int         n;
        int         pp;
        int         rp;
        int         lp;
        logic       pr;
        logic [7:0] cnt;
    } seg_t;

    logic       fclock;
    logic       lock;
    logic       btn;
    logic       btn_n;
    logic       pr_p, pp_p, rp_p, lp_p;
    logic       pr_n, pp_n, rp_n, lp_n;
    logic [7:0] cnt_p, cnt_n;

    int n_tests;
    int n_fail;
    int cyc;
    int pp_q[$];
    int rp_q[$];
    int lp_q[$];
    logic e_pp, e_rp, e_lp;
    seg_t tbl[13];

    assign btn_n = ~btn;

    button_debounce #(.DEBOUNCE_CYCLES(4), .LONG_CYCLES(10), .ACTIVE_HIGH(1)) dut_p (
        .fclock(fclock), .lock(lock), .button(btn),
        .pressed(pr_p), .press_pulse(pp_p), .release_pulse(rp_p),
        .long_pulse(lp_p), .press_count(cnt_p)
    );

    button_debounce #(.DEBOUNCE_CYCLES(4), .LONG_CYCLES(10), .ACTIVE_HIGH(0)) dut_n (
        .fclock(fclock), .lock(lock), .button(btn_n),
        .pressed(pr_n), .press_pulse(pp_n), .release_pulse(rp_n),
        .long_pulse(lp_n), .press_count(cnt_n)
    );

    initial fclock = 1'b0;
    always #5 fclock = ~fclock;

    always @(posedge fclock) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests = n_tests + 1;
        if (act !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s at cycle %0d: actual=%0d expected=%0d", name, cyc, act, exp);
        end
    endtask

    // Scoreboard monitor: a pulse is expected exactly when its queue head names this cycle.
    always @(negedge fclock) begin
        e_pp = 1'b0;
        e_rp = 1'b0;
        e_lp = 1'b0;
        if (pp_q.size() > 0) begin
            if (pp_q[0] == cyc) begin
                e_pp = 1'b1;
                void'(pp_q.pop_front());
            end
        end
        if (rp_q.size() > 0) begin
            if (rp_q[0] == cyc) begin
                e_rp = 1'b1;
                void'(rp_q.pop_front());
            end
        end
        if (lp_q.size() > 0) begin
            if (lp_q[0] == cyc) begin
                e_lp = 1'b1;
                void'(lp_q.pop_front());
            end
        end
        chk("press_pulse_hi",   32'(pp_p), 32'(e_pp));
        chk("press_pulse_lo",   32'(pp_n), 32'(e_pp));
        chk("release_pulse_hi", 32'(rp_p), 32'(e_rp));
        chk("release_pulse_lo", 32'(rp_n), 32'(e_rp));
        chk("long_pulse_hi",    32'(lp_p), 32'(e_lp));
        chk("long_pulse_lo",    32'(lp_n), 32'(e_lp));
    end

    // Entered and left at a negedge; offsets are edge indices within the segment.
    task automatic run_seg(input seg_t s);
        int base;
        base = cyc + 1;
        if (s.pp >= 0) pp_q.push_back(base + s.pp);
        if (s.rp >= 0) rp_q.push_back(base + s.rp);
        if (s.lp >= 0) lp_q.push_back(base + s.lp);
        for (int i = 0; i < s.n; i++) begin
            btn = s.b;
            @(negedge fclock);
        end
        chk("seg_pressed_hi", 32'(pr_p), 32'(s.pr));
        chk("seg_pressed_lo", 32'(pr_n), 32'(s.pr));
        chk("seg_count_hi",   32'(cnt_p), 32'(s.cnt));
        chk("seg_count_lo",   32'(cnt_n), 32'(s.cnt));
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, "_pressed_hi"}, 32'(pr_p), 32'd0);
        chk({name, "_pressed_lo"}, 32'(pr_n), 32'd0);
        chk({name, "_count_hi"},   32'(cnt_p), 32'd0);
        chk({name, "_count_lo"},   32'(cnt_n), 32'd0);
        chk({name, "_pulses_hi"},  32'({pp_p, rp_p, lp_p}), 32'd0);
        chk({name, "_pulses_lo"},  32'({pp_n, rp_n, lp_n}), 32'd0);
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        cyc     = 0;
        lock    = 1'b0;
        btn     = 1'b0;

        //           b     n   pp  rp  lp  pr    cnt
        tbl[0]  = '{1'b0, 20, -1, -1, -1, 1'b0, 8'd0};
        tbl[1]  = '{1'b1,  8,  5, -1, -1, 1'b1, 8'd1};
        tbl[2]  = '{1'b0,  8, -1,  5, -1, 1'b0, 8'd1};
        tbl[3]  = '{1'b1,  3, -1, -1, -1, 1'b0, 8'd1};
        tbl[4]  = '{1'b0,  1, -1, -1, -1, 1'b0, 8'd1};
        tbl[5]  = '{1'b1,  3, -1, -1, -1, 1'b0, 8'd1};
        tbl[6]  = '{1'b0, 10, -1, -1, -1, 1'b0, 8'd1};
        tbl[7]  = '{1'b1,  8,  5, -1, -1, 1'b1, 8'd2};
        tbl[8]  = '{1'b0,  1, -1, -1, -1, 1'b1, 8'd2};
        tbl[9]  = '{1'b1,  8, -1, -1,  6, 1'b1, 8'd2};
        tbl[10] = '{1'b0,  8, -1,  5, -1, 1'b0, 8'd2};
        tbl[11] = '{1'b1, 40,  5, -1, 15, 1'b1, 8'd3};
        tbl[12] = '{1'b0,  8, -1,  5, -1, 1'b0, 8'd3};

        // Reset held while the pad toggles.
        for (int i = 0; i < 6; i++) begin
            @(negedge fclock);
            btn = (i % 2 == 1) ? 1'b1 : 1'b0;
            chk_all_zero("in_reset");
        end
        @(negedge fclock);
        lock = 1'b1;

        for (int i = 0; i < 13; i++) begin
            run_seg(tbl[i]);
        end

        // Asynchronous reset in the middle of a held press.
        run_seg('{1'b1, 8, 5, -1, -1, 1'b1, 8'd4});
        lock = 1'b0;
        #1;
        chk_all_zero("async_reset");
        for (int i = 0; i < 3; i++) begin
            @(negedge fclock);
            chk_all_zero("reset_hold");
        end
        lock = 1'b1;
        run_seg('{1'b1, 8, 5, -1, -1, 1'b1, 8'd1});
        run_seg('{1'b0, 8, -1, 5, -1, 1'b0, 8'd1});

        // Counter wrap: 257 presses from a fresh reset.
        lock = 1'b0;
        #1;
        chk_all_zero("wrap_reset");
        @(negedge fclock);
        @(negedge fclock);
        lock = 1'b1;
        for (int i = 0; i < 257; i++) begin
            run_seg('{1'b1, 7, 5, -1, -1, 1'b1, 8'((i + 1) % 256)});
            run_seg('{1'b0, 7, -1, 5, -1, 1'b0, 8'((i + 1) % 256)});
        end
        chk("wrap_count_hi", 32'(cnt_p), 32'd1);
        chk("wrap_count_lo", 32'(cnt_n), 32'd1);

        @(negedge fclock);
        chk("pending_pulses", 32'(pp_q.size() + rp_q.size() + lp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
